test004: RTL and testbench

//  Method-call block for loop-control checks (break / continue), one
//  req/busy handshake per method, plus thread-style run/start/join/yield.
//  A 32-bit field i is readable and writable from outside.

---
 rtl/test004.sv | 184 ++++++++++++++++++
 tb/tb_test004.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/test004.sv
// rtl/test004.sv - method-call block: break/continue loop checks, test/run/start/join/yield FSMs
// Each method owns a req/busy FSM; nested calls reuse the callee FSMs so their busy is visible.
module test004 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_in,
  input  logic        i_we,
  output logic [31:0] i_out,
  input  logic        run_req,
  output logic        run_busy,
  input  logic        break_test_req,
  output logic        break_test_busy,
  input  logic        continue_test_req,
  output logic        continue_test_busy,
  output logic        continue_test_return,
  input  logic        test_req,
  output logic        test_busy,
  output logic        test_return,
  input  logic        start_req,
  output logic        start_busy,
  input  logic        join_req,
  output logic        join_busy,
  input  logic        yield_req,
  output logic        yield_busy
);

  localparam logic [1:0] BT_IDLE = 2'd0, BT_INIT = 2'd1, BT_LOOP = 2'd2;
  localparam logic [0:0] CT_IDLE = 1'b0, CT_LOOP = 1'b1;
  localparam logic [2:0] T_IDLE = 3'd0, T_BT_CALL = 3'd1, T_BT_WAIT = 3'd2,
                         T_CT_CALL = 3'd3, T_CT_WAIT = 3'd4;
  localparam logic [1:0] R_IDLE = 2'd0, R_CALL = 2'd1, R_WAIT = 2'd2;
  localparam logic [0:0] S_IDLE = 1'b0, S_ACT = 1'b1;
  localparam logic [0:0] J_IDLE = 1'b0, J_WAIT = 1'b1;
  localparam logic [0:0] Y_IDLE = 1'b0, Y_BUSY = 1'b1;

  logic [31:0] i_q;
  logic [1:0]  bt_state;
  logic [0:0]  ct_state;
  logic [2:0]  t_state;
  logic [1:0]  r_state;
  logic [0:0]  s_state, j_state, y_state;
  logic [3:0]  ct_k;
  logic [31:0] ct_sum;
  logic        ct_ret, t_ret, t_r;

  logic        bt_call, ct_call, run_call, start_launch;
  logic        bt_launch, ct_launch, test_launch, run_launch;
  logic        bt_done, bt_we;
  logic [31:0] bt_wdata;

  assign bt_call      = (t_state == T_BT_CALL) && (bt_state == BT_IDLE);
  assign ct_call      = (t_state == T_CT_CALL) && (ct_state == CT_IDLE);
  assign run_call     = (r_state == R_CALL) && (t_state == T_IDLE);
  assign start_launch = (s_state == S_ACT) && (r_state == R_IDLE);

  assign bt_launch   = break_test_req | bt_call;
  assign ct_launch   = continue_test_req | ct_call;
  assign test_launch = test_req | run_call;
  assign run_launch  = run_req | start_launch;

  // The loop bound (i<10) only matters if i starts outside 0..5, which cannot happen after INIT.
  assign bt_done  = (i_q == 32'd5) || ($signed(i_q) >= 32'sd10);
  assign bt_we    = (bt_state == BT_INIT) || ((bt_state == BT_LOOP) && !bt_done);
  assign bt_wdata = (bt_state == BT_INIT) ? 32'd0 : i_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= 32'd0;
    end else if (bt_we) begin
      i_q <= bt_wdata;
    end else if (i_we && (bt_state == BT_IDLE)) begin
      i_q <= i_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bt_state <= BT_IDLE;
    end else begin
      case (bt_state)
        BT_IDLE: if (bt_launch) bt_state <= BT_INIT;
        BT_INIT: bt_state <= BT_LOOP;
        BT_LOOP: if (bt_done) bt_state <= BT_IDLE;
        default: bt_state <= BT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ct_state <= CT_IDLE;
      ct_k     <= 4'd0;
      ct_sum   <= 32'd0;
      ct_ret   <= 1'b0;
    end else begin
      case (ct_state)
        CT_IDLE: begin
          if (ct_launch) begin
            ct_state <= CT_LOOP;
            ct_k     <= 4'd0;
            ct_sum   <= 32'd0;
          end
        end
        default: begin
          if (ct_k == 4'd10) begin
            ct_state <= CT_IDLE;
            ct_ret   <= (ct_sum == 32'd20);
          end else begin
            if (!ct_k[0]) ct_sum <= ct_sum + {28'd0, ct_k};
            ct_k <= ct_k + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_state <= T_IDLE;
      t_r     <= 1'b0;
      t_ret   <= 1'b0;
    end else begin
      case (t_state)
        T_IDLE:    if (test_launch) t_state <= T_BT_CALL;
        T_BT_CALL: if (bt_call) t_state <= T_BT_WAIT;
        T_BT_WAIT: begin
          if (bt_state == BT_IDLE) begin
            t_r     <= (i_q == 32'd5);
            t_state <= T_CT_CALL;
          end
        end
        T_CT_CALL: if (ct_call) t_state <= T_CT_WAIT;
        T_CT_WAIT: begin
          if (ct_state == CT_IDLE) begin
            t_ret   <= t_r && ct_ret;
            t_state <= T_IDLE;
          end
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE:  if (run_launch) r_state <= R_CALL;
        R_CALL:  if (run_call) r_state <= R_WAIT;
        R_WAIT:  if (t_state == T_IDLE) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_state <= S_IDLE;
      j_state <= J_IDLE;
      y_state <= Y_IDLE;
    end else begin
      s_state <= (s_state == S_IDLE) ? (start_req ? S_ACT : S_IDLE) : S_IDLE;
      if (j_state == J_IDLE) begin
        if (join_req) j_state <= J_WAIT;
      end else if (r_state == R_IDLE) begin
        j_state <= J_IDLE;
      end
      y_state <= (y_state == Y_IDLE) ? (yield_req ? Y_BUSY : Y_IDLE) : Y_IDLE;
    end
  end

  assign i_out                = i_q;
  assign break_test_busy      = (bt_state != BT_IDLE);
  assign continue_test_busy   = (ct_state != CT_IDLE);
  assign continue_test_return = ct_ret;
  assign test_busy            = (t_state != T_IDLE);
  assign test_return          = t_ret;
  assign run_busy             = (r_state != R_IDLE);
  assign start_busy           = (s_state != S_IDLE);
  assign join_busy            = (j_state != J_IDLE);
  assign yield_busy           = (y_state != Y_IDLE);

endmodule

// File: tb/tb_test004.sv
// tb/tb_test004.sv - scoreboard bench for test004
// Stimulus pushes expected completion events; a monitor pops them on each busy falling edge.
module tb_test004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_in;
  logic        i_we;
  logic [31:0] i_out;
  logic        run_req, run_busy;
  logic        break_test_req, break_test_busy;
  logic        continue_test_req, continue_test_busy, continue_test_return;
  logic        test_req, test_busy, test_return;
  logic        start_req, start_busy;
  logic        join_req, join_busy;
  logic        yield_req, yield_busy;

  always #5 clk = ~clk;

  test004 dut (
    .clk(clk), .reset(reset), .i_in(i_in), .i_we(i_we), .i_out(i_out),
    .run_req(run_req), .run_busy(run_busy),
    .break_test_req(break_test_req), .break_test_busy(break_test_busy),
    .continue_test_req(continue_test_req), .continue_test_busy(continue_test_busy),
    .continue_test_return(continue_test_return),
    .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
    .start_req(start_req), .start_busy(start_busy),
    .join_req(join_req), .join_busy(join_busy),
    .yield_req(yield_req), .yield_busy(yield_busy)
  );

  localparam int K_START = 0, K_BT = 1, K_CT = 2, K_TEST = 3, K_RUN = 4, K_JOIN = 5;

  typedef struct {
    int          kind;
    logic        ret;
    logic [31:0] iv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  string kname[6] = '{"start", "break_test", "continue_test", "test", "run", "join"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic r, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.ret  = r;
    e.iv   = v;
    sb.push_back(e);
  endtask

  task automatic on_event(input int k, input logic act_ret);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: completion with empty scoreboard ret=%0b i=0x%08h", kname[k], act_ret, i_out);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.ret !== act_ret || e.iv !== i_out) begin
        failures++;
        $display("FAIL event_%s: got %s ret=%0b i=0x%08h expected %s ret=%0b i=0x%08h",
                 kname[e.kind], kname[k], act_ret, i_out, kname[e.kind], e.ret, e.iv);
      end
    end
  endtask

  initial begin
    logic p_start = 1'b0, p_bt = 1'b0, p_ct = 1'b0, p_test = 1'b0, p_run = 1'b0, p_join = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_start && !start_busy)         on_event(K_START, run_busy);
        if (p_bt && !break_test_busy)       on_event(K_BT, 1'b0);
        if (p_ct && !continue_test_busy)    on_event(K_CT, continue_test_return);
        if (p_test && !test_busy)           on_event(K_TEST, test_return);
        if (p_run && !run_busy)             on_event(K_RUN, test_return);
        if (p_join && !join_busy)           on_event(K_JOIN, test_return);
      end
      p_start = start_busy;
      p_bt    = break_test_busy;
      p_ct    = continue_test_busy;
      p_test  = test_busy;
      p_run   = run_busy;
      p_join  = join_busy;
    end
  end

  function automatic logic busy_of(input int k);
    case (k)
      K_START: return start_busy;
      K_BT:    return break_test_busy;
      K_CT:    return continue_test_busy;
      K_TEST:  return test_busy;
      K_RUN:   return run_busy;
      default: return join_busy;
    endcase
  endfunction

  task automatic wait_idle(input int k, input int budget);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (!busy_of(k)) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout_%s: busy still 1 after %0d cycles, expected 0", kname[k], budget);
    end
  endtask

  task automatic pulse_test_seq();
    push(K_BT, 1'b0, 32'd5);
    push(K_CT, 1'b1, 32'd5);
    push(K_TEST, 1'b1, 32'd5);
  endtask

  initial begin
    reset = 1'b1; i_in = 32'd0; i_we = 1'b0;
    run_req = 0; break_test_req = 0; continue_test_req = 0; test_req = 0;
    start_req = 0; join_req = 0; yield_req = 0;
    repeat (6) @(negedge clk);
    check("reset_busy", {run_busy, break_test_busy, continue_test_busy, test_busy,
                         start_busy, join_busy, yield_busy}, 32'd0);
    check("reset_returns", {test_return, continue_test_return}, 32'd0);
    check("reset_i", i_out, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // test() with req held high until the first idle cycle
    while (cyc < 100) @(negedge clk);
    pulse_test_seq();
    test_req = 1'b1;
    repeat (2) @(negedge clk);
    check("test_busy_rise", test_busy, 1);
    wait_idle(K_TEST, 38);
    test_req = 1'b0;
    check("test_i_after", i_out, 32'd5);
    repeat (3) @(negedge clk);

    // continue_test() leaves i untouched
    i_in = 32'h77; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    push(K_CT, 1'b1, 32'h77);
    continue_test_req = 1'b1;
    @(negedge clk);
    continue_test_req = 1'b0;
    wait_idle(K_CT, 20);
    repeat (2) @(negedge clk);

    // external write, then break_test() overrides it; i_we while busy is ignored
    i_in = 32'hDEADBEEF; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    check("we_deadbeef", i_out, 32'hDEADBEEF);
    push(K_BT, 1'b0, 32'd5);
    break_test_req = 1'b1;
    @(negedge clk);
    break_test_req = 1'b0;
    check("bt_first_read", i_out, 32'hDEADBEEF);
    @(negedge clk);
    i_in = 32'h1234; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    wait_idle(K_BT, 20);
    repeat (2) @(negedge clk);

    // yield held high: busy 1, idle gap, relaunch
    yield_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("yield_pat%0d", n), yield_busy, (n % 2 == 0) ? 1 : 0);
    end
    yield_req = 1'b0;
    @(negedge clk);
    check("yield_released", yield_busy, 0);

    // start() then join()
    push(K_START, 1'b1, 32'd5);
    pulse_test_seq();
    push(K_RUN, 1'b1, 32'd5);
    push(K_JOIN, 1'b1, 32'd5);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    join_req = 1'b1;
    @(negedge clk);
    join_req = 1'b0;
    for (int n = 0; n < 60 && join_busy; n++) begin
      if (run_busy) check("join_covers_run", join_busy, 1);
      @(negedge clk);
    end
    wait_idle(K_JOIN, 5);
    repeat (2) @(negedge clk);

    // reset while test() is running, then re-issue
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", test_busy, 1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {run_busy, break_test_busy, continue_test_busy, test_busy,
                         start_busy, join_busy, yield_busy}, 32'd0);
    check("abort_i", i_out, 32'd0);
    check("abort_return", test_return, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    pulse_test_seq();
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    wait_idle(K_TEST, 40);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
